dist_sq: RTL

- Upstream feeder for the fixed-point square-root stage: computes the squared distance (x1-x0)^2 + (y1-y0)^2 between two ball/cushion positions.
- Result is in the same unsigned fixed-point format the root stage consumes on num_in.
- Uses one shared sequential shift-add multiplier for both squares, with a start/busy/done handshake, so the cushion/ball collision path uses no DSP multipliers.

---
 rtl/dist_sq_pkg.sv | 16 +
 rtl/dist_sq_mult.sv | 59 +++++
 rtl/dist_sq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dist_sq_pkg.sv
// Shared types and sizing for the squared-distance feeder.
package dist_sq_pkg;
   localparam int DEF_WIDTH      = 32;
   localparam int DEF_FRAC_WIDTH = 30;
   localparam int MAG_W          = DEF_WIDTH + 1;
   localparam int PROD_W         = 2 * MAG_W;
   localparam int LATENCY        = 2 * DEF_WIDTH + 4;

   typedef enum logic [2:0] {
      IDLE,
      DIFF,
      MUL_X,
      MUL_Y,
      SUM
   } state_e;
endpackage

// File: rtl/dist_sq_mult.sv
// Unsigned shift-add multiplier; load consumes multiplier bit 0, each step one more bit.
module seq_mult_u
   import dist_sq_pkg::*;
#(
   parameter int W = MAG_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           last,
   output logic [2*W-1:0] product
);
   localparam int PW = 2 * W;
   localparam int CW = $clog2(W + 1);

   logic [PW-1:0] acc_q, acc_d;
   logic [PW-1:0] mcand_q, mcand_d;
   logic [W-1:0]  mplier_q, mplier_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (load) begin
         acc_d    = b[0] ? PW'(a) : '0;
         mcand_d  = PW'(a) << 1;
         mplier_d = b >> 1;
         cnt_d    = CW'(1);
      end else if (step && (cnt_q < CW'(W))) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
      end
   end

   // The step taken while last is high retires the final multiplier bit.
   assign last    = (cnt_q == CW'(W - 1));
   assign product = acc_q;
endmodule

// File: rtl/dist_sq.sv
// Squared distance between two signed fixed-point points, one shared sequential multiplier.
module dist_sq
   import dist_sq_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] y0,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] y1,
   output logic             busy,
   output logic             done,
   output logic             sat,
   output logic [WIDTH-1:0] out
);
   localparam int MW = WIDTH + 1;
   localparam int PW = 2 * MW;
   localparam int SW = PW + 1;

   state_e state_q, state_d;
   logic [WIDTH-1:0] x0_q, y0_q, x1_q, y1_q, x0_d, y0_d, x1_d, y1_d;
   logic [MW-1:0]    magx_q, magy_q, magx_d, magy_d;
   logic [PW-1:0]    px_q, px_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             sat_q, sat_d, done_q, done_d, ld_q, ld_d;

   logic signed [MW-1:0] dx, dy;
   logic [SW-1:0]        s, r;
   logic                 mul_act, mul_load, mul_step, mul_last;
   logic [MW-1:0]        mul_a;
   logic [PW-1:0]        mul_prod;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         magx_q  <= '0;
         magy_q  <= '0;
         px_q    <= '0;
         out_q   <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         ld_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         magx_q  <= magx_d;
         magy_q  <= magy_d;
         px_q    <= px_d;
         out_q   <= out_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
         ld_q    <= ld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = DIFF;
         DIFF:    state_d = MUL_X;
         MUL_X:   if (!ld_q && mul_last) state_d = MUL_Y;
         MUL_Y:   if (!ld_q && mul_last) state_d = SUM;
         SUM:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mul_act  = (state_q == MUL_X) || (state_q == MUL_Y);
   assign mul_load = mul_act && ld_q;
   assign mul_step = mul_act && !ld_q;
   assign mul_a    = (state_q == MUL_Y) ? magy_q : magx_q;

   seq_mult_u #(.W(MW)) u_mult (
      .clk     (clk),
      .rst     (rst),
      .load    (mul_load),
      .step    (mul_step),
      .a       (mul_a),
      .b       (mul_a),
      .last    (mul_last),
      .product (mul_prod)
   );

   always_comb begin
      dx = $signed({x1_q[WIDTH-1], x1_q}) - $signed({x0_q[WIDTH-1], x0_q});
      dy = $signed({y1_q[WIDTH-1], y1_q}) - $signed({y0_q[WIDTH-1], y0_q});
      s  = SW'(px_q) + SW'(mul_prod);
      r  = s >> FRAC_WIDTH;
   end

   always_comb begin
      x0_d   = x0_q;
      y0_d   = y0_q;
      x1_d   = x1_q;
      y1_d   = y1_q;
      magx_d = magx_q;
      magy_d = magy_q;
      px_d   = px_q;
      out_d  = out_q;
      sat_d  = sat_q;
      done_d = 1'b0;
      // First cycle of each multiply phase loads the operand instead of stepping.
      ld_d   = (state_d != state_q) && ((state_d == MUL_X) || (state_d == MUL_Y));
      case (state_q)
         IDLE: if (start) begin
            x0_d = x0;
            y0_d = y0;
            x1_d = x1;
            y1_d = y1;
         end
         DIFF: begin
            magx_d = dx[MW-1] ? -dx : dx;
            magy_d = dy[MW-1] ? -dy : dy;
         end
         MUL_Y: if (ld_q) px_d = mul_prod;
         SUM: begin
            sat_d  = |r[SW-1:WIDTH];
            out_d  = (|r[SW-1:WIDTH]) ? '1 : r[WIDTH-1:0];
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = done_q;
      sat  = sat_q;
      out  = out_q;
   end
endmodule
